ex_div: RTL and testbench

- Iterative radix-2 integer divider inside the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded M-extension divide/remainder uop and its operands: DIV, DIVU, REM, REMU.
- Asserts a stall request to the ctrl unit while iterating, then presents a one-cycle-valid result to EX writeback muxing.

---
 rtl/ex_div.sv | 143 ++++++++++++++
 tb/tb_ex_div.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 flush_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [DIV_WIDTH-1:0] dividend_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  input  logic [4:0]           rd_addr_i,
  output logic [DIV_WIDTH-1:0] result_o,
  output logic                 ready_o,
  output logic [4:0]           rd_addr_o,
  output logic                 busy_o,
  output logic                 stall_req_o
);

  localparam int CW = $clog2(DIV_WIDTH) + 1;
  localparam logic [DIV_WIDTH-1:0] MIN_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] quo_q;
  logic [DIV_WIDTH-1:0] rem_q;
  logic [DIV_WIDTH-1:0] dvs_q;
  logic [CW-1:0]        cnt_q;
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic                 sel_rem_q;

  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [DIV_WIDTH-1:0] a_mag;
  logic [DIV_WIDTH-1:0] b_mag;
  logic                 div_zero;
  logic                 overflow;
  logic                 early;

  logic [DIV_WIDTH:0]   rem_shift;
  logic                 step_ok;
  logic [DIV_WIDTH-1:0] rem_n;
  logic [DIV_WIDTH-1:0] quo_n;
  logic [DIV_WIDTH-1:0] q_fix;
  logic [DIV_WIDTH-1:0] r_fix;

  // Operand conditioning at acceptance: magnitudes and the special-case detectors.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[DIV_WIDTH-1];
    b_neg     = is_signed & divisor_i[DIV_WIDTH-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    overflow  = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
  end

  // One restoring step; the partial remainder is always below the divisor,
  // so the low bits of the difference are exact.
  always_comb begin
    rem_shift = {rem_q, quo_q[DIV_WIDTH-1]};
    step_ok   = (rem_shift >= {1'b0, dvs_q});
    rem_n     = step_ok ? (rem_shift[DIV_WIDTH-1:0] - dvs_q) : rem_shift[DIV_WIDTH-1:0];
    quo_n     = {quo_q[DIV_WIDTH-2:0], step_ok};
    q_fix     = q_neg_q ? -quo_n : quo_n;
    r_fix     = r_neg_q ? -rem_n : rem_n;
  end

  assign busy_o      = (state_q != IDLE);
  assign ready_o     = (state_q == DONE) & ~flush_i;
  assign stall_req_o = ~flush_i & (((state_q == IDLE) & start_i) | (state_q == CALC));

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sel_rem_q <= op_i[1];
            rd_addr_o <= rd_addr_i;
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            cnt_q     <= '0;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            // Special cases resolve immediately and skip the fix-up path.
            if (div_zero) begin
              result_o <= op_i[1] ? dividend_i : '1;
              state_q  <= DONE;
            end else if (overflow) begin
              result_o <= op_i[1] ? '0 : MIN_NEG;
              state_q  <= DONE;
            end else if (early) begin
              result_o <= op_i[1] ? dividend_i : '0;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            result_o <= sel_rem_q ? r_fix : q_fix;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, stall, signed fix-up, specials, flush, reset.
module tb_ex_div;

  logic        clk_i;
  logic        n_rst_i;
  logic        flush_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  rd_addr_o;
  logic        busy_o;
  logic        stall_req_o;

  int compared;
  int mismatched;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  ex_div #(.DIV_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .n_rst_i     (n_rst_i),
    .flush_i     (flush_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_addr_i   (rd_addr_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .rd_addr_o   (rd_addr_o),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Issues one divide with start held until ready; lat=-1 means it never completed.
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output int stalls);
    lat = -1;
    stalls = 0;
    res = '0;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    rd_addr_i = rd;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (stall_req_o) stalls++;
      if (ready_o) begin
        lat = c;
        res = result_o;
        start_i = 1'b0;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if (result_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
    compared++;
    if (ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    compared++;
    if (rd_addr_o !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rd: got %0d expected 0", rd_addr_o); end
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat, st;
    run_div(OP_DIVU, 32'd100, 32'd7, 5'd5, res, lat, st);
    compared++;
    if (res !== 32'd14) begin mismatched++; $display("[TB] FAIL divu_100_7: got %h expected %h", res, 32'd14); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL divu_latency: got %0d expected 33", lat); end
    compared++;
    if (st !== 33) begin mismatched++; $display("[TB] FAIL divu_stall_cycles: got %0d expected 33", st); end
    compared++;
    if (rd_addr_o !== 5'd5) begin mismatched++; $display("[TB] FAIL divu_rd_addr: got %0d expected 5", rd_addr_o); end
    run_div(OP_REMU, 32'd100, 32'd7, 5'd6, res, lat, st);
    compared++;
    if (res !== 32'd2) begin mismatched++; $display("[TB] FAIL remu_100_7: got %h expected 2", res); end
    compared++;
    if (rd_addr_o !== 5'd6) begin mismatched++; $display("[TB] FAIL remu_rd_addr: got %0d expected 6", rd_addr_o); end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int lat, st;
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFD) begin mismatched++; $display("[TB] FAIL div_m7_2: got %h expected fffffffd", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
    run_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL rem_m7_2: got %h expected ffffffff", res); end
    run_div(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd3, res, lat, st);
    compared++;
    if (res !== 32'd1) begin mismatched++; $display("[TB] FAIL rem_7_m2: got %h expected 1", res); end
    run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFD) begin mismatched++; $display("[TB] FAIL div_7_m2: got %h expected fffffffd", res); end
    run_div(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd4, res, lat, st);
    compared++;
    if (res !== 32'h7FFF_FFFC) begin mismatched++; $display("[TB] FAIL divu_big_2: got %h expected 7ffffffc", res); end
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat, st;
    run_div(OP_DIV, 32'd5, 32'd0, 5'd10, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL div_by_zero: got %h expected ffffffff", res); end
    compared++;
    if (lat !== 1) begin mismatched++; $display("[TB] FAIL div_by_zero_latency: got %0d expected 1", lat); end
    compared++;
    if (st !== 1) begin mismatched++; $display("[TB] FAIL div_by_zero_stall: got %0d expected 1", st); end
    run_div(OP_REMU, 32'd5, 32'd0, 5'd11, res, lat, st);
    compared++;
    if (res !== 32'd5) begin mismatched++; $display("[TB] FAIL remu_by_zero: got %h expected 5", res); end
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, res, lat, st);
    compared++;
    if (res !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL div_overflow: got %h expected 80000000", res); end
    compared++;
    if (lat !== 1) begin mismatched++; $display("[TB] FAIL div_overflow_latency: got %0d expected 1", lat); end
    run_div(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, res, lat, st);
    compared++;
    if (res !== 32'h0) begin mismatched++; $display("[TB] FAIL rem_overflow: got %h expected 0", res); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, st;
    bit seen;
    seen = 1'b0;
    // Flush together with start in IDLE must not accept.
    @(posedge clk_i);
    #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU;
    dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd7;
    #1;
    compared++;
    if (stall_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_start_stall: got %b expected 0", stall_req_o); end
    @(posedge clk_i);
    #1;
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_start_busy: got %b expected 0", busy_o); end
    flush_i = 1'b0;
    // start_i still high: accepted on the next edge, then flushed at cycle 10.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (ready_o) seen = 1'b1;
    end
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    compared++;
    if (stall_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_calc_stall: got %b expected 0", stall_req_o); end
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_calc_idle: got %b expected 0", busy_o); end
    repeat (40) begin
      @(negedge clk_i);
      if (ready_o) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_ready: got %b expected 0", seen); end
    run_div(OP_DIVU, 32'd9, 32'd3, 5'd8, res, lat, st);
    compared++;
    if (res !== 32'd3) begin mismatched++; $display("[TB] FAIL after_flush_9_3: got %h expected 3", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL after_flush_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, st;
    @(posedge clk_i);
    #1;
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd9;
    repeat (6) @(negedge clk_i);
    start_i = 1'b0;
    #2;
    n_rst_i = 1'b0;
    #1;
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL async_rst_busy: got %b expected 0", busy_o); end
    compared++;
    if (result_o !== 32'h0) begin mismatched++; $display("[TB] FAIL async_rst_result: got %h expected 0", result_o); end
    compared++;
    if (rd_addr_o !== 5'd0) begin mismatched++; $display("[TB] FAIL async_rst_rd: got %0d expected 0", rd_addr_o); end
    compared++;
    if (stall_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL async_rst_stall: got %b expected 0", stall_req_o); end
    #3;
    n_rst_i = 1'b1;
    run_div(OP_DIVU, 32'd20, 32'd4, 5'd14, res, lat, st);
    compared++;
    if (res !== 32'd5) begin mismatched++; $display("[TB] FAIL after_reset_20_4: got %h expected 5", res); end
  endtask

  task automatic test_early_out();
    logic [31:0] res;
    int lat, st;
    run_div(OP_DIVU, 32'd3, 32'd10, 5'd15, res, lat, st);
    compared++;
    if (res !== 32'd0) begin mismatched++; $display("[TB] FAIL small_divu_3_10: got %h expected 0", res); end
    compared++;
    if (lat !== EARLY_LAT) begin mismatched++; $display("[TB] FAIL small_divu_latency: got %0d expected %0d", lat, EARLY_LAT); end
    run_div(OP_REMU, 32'd3, 32'd10, 5'd16, res, lat, st);
    compared++;
    if (res !== 32'd3) begin mismatched++; $display("[TB] FAIL small_remu_3_10: got %h expected 3", res); end
    run_div(OP_REM, 32'hFFFF_FFFD, 32'd10, 5'd17, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFD) begin mismatched++; $display("[TB] FAIL small_rem_m3_10: got %h expected fffffffd", res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, st;
    run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd18, res, lat, st);
    compared++;
    if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL b2b_div_by_one: got %h expected ffffffff", res); end
    run_div(OP_REMU, 32'd1000, 32'd33, 5'd19, res, lat, st);
    compared++;
    if (res !== 32'd10) begin mismatched++; $display("[TB] FAIL b2b_remu_1000_33: got %h expected a", res); end
    compared++;
    if (rd_addr_o !== 5'd19) begin mismatched++; $display("[TB] FAIL b2b_rd_addr: got %0d expected 19", rd_addr_o); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    n_rst_i = 1'b0;
    flush_i = 1'b0;
    start_i = 1'b0;
    op_i = 2'b00;
    dividend_i = '0;
    divisor_i = '0;
    rd_addr_i = '0;
    repeat (3) @(negedge clk_i);
    test_reset();
    n_rst_i = 1'b1;
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_async_reset();
    test_early_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
